// File: rtl/ms_latch_sequencer_pkg.sv
// Shared definitions for the master/slave latch sequencer: one-hot state encoding,
// default phase lengths and the phase-counter sizing helper.
package ms_latch_sequencer_pkg;

  typedef enum logic [5:0] {
    StIdle  = 6'b000001,
    StMOpen = 6'b000010,
    StGap1  = 6'b000100,
    StSOpen = 6'b001000,
    StGap2  = 6'b010000,
    StDone  = 6'b100000
  } state_e;

  localparam int unsigned DefWidth      = 2;
  localparam int unsigned DefOpenCycles = 2;
  localparam int unsigned DefGapCycles  = 1;

  // Counter must hold values up to the longest phase length.
  function automatic int unsigned phase_cnt_width(input int unsigned open_cycles,
                                                  input int unsigned gap_cycles);
    int unsigned longest;
    longest = (open_cycles > gap_cycles) ? open_cycles : gap_cycles;
    return (longest < 1) ? 1 : $clog2(longest + 1);
  endfunction

endpackage

// File: rtl/ms_latch_pair.sv
// One master/slave D-latch slice. Each stage is a register with a transparent
// bypass while its enable is high, so the output follows like a real latch.
module ms_latch_pair (
  input  logic clk,
  input  logic rst,
  input  logic d,
  input  logic men,
  input  logic sen,
  output logic q
);

  logic master_q;
  logic slave_q;
  logic master_out;

  assign master_out = men ? d : master_q;
  assign q          = sen ? master_out : slave_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      master_q <= 1'b0;
      slave_q  <= 1'b0;
    end else begin
      if (men) master_q <= d;
      if (sen) slave_q  <= master_out;
    end
  end

endmodule

// File: rtl/ms_latch_sequencer.sv
// Two-phase sequencer: accepts a write on a 4-phase req/ack handshake and drives
// non-overlapping master/slave enables over a bank of latch pairs.
module ms_latch_sequencer
  import ms_latch_sequencer_pkg::*;
#(
  parameter int unsigned WIDTH       = DefWidth,
  parameter int unsigned OPEN_CYCLES = DefOpenCycles,
  parameter int unsigned GAP_CYCLES  = DefGapCycles
) (
  input  logic             input_clock1_clk_1,
  input  logic             input_reset1_rst_2,
  input  logic             input_write_req_3,
  input  logic [WIDTH-1:0] input_data_d_4,
  output logic             output_ack_5,
  output logic             output_busy_6,
  output logic             output_master_en_7,
  output logic             output_slave_en_8,
  output logic [WIDTH-1:0] output_led_q_9
);

  localparam int unsigned CntW = phase_cnt_width(OPEN_CYCLES, GAP_CYCLES);
  localparam logic [CntW-1:0] OpenLast = CntW'(OPEN_CYCLES - 1);
  localparam logic [CntW-1:0] GapLast  = CntW'(GAP_CYCLES - 1);

  if (WIDTH < 1) begin : g_width_chk
    $error("ms_latch_sequencer: WIDTH must be at least 1");
  end
  if (OPEN_CYCLES < 1) begin : g_open_chk
    $error("ms_latch_sequencer: OPEN_CYCLES must be at least 1");
  end
  if (GAP_CYCLES < 1) begin : g_gap_chk
    $error("ms_latch_sequencer: GAP_CYCLES must be at least 1");
  end

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]  hold_q;
  logic              master_en;
  logic              slave_en;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CntW'(1);
    unique case (state_q)
      StIdle:  if (input_write_req_3) state_d = StMOpen;
      StMOpen: if (cnt_q == OpenLast) state_d = StGap1;
      StGap1:  if (cnt_q == GapLast)  state_d = StSOpen;
      StSOpen: if (cnt_q == OpenLast) state_d = StGap2;
      StGap2:  if (cnt_q == GapLast)  state_d = StDone;
      StDone:  if (!input_write_req_3) state_d = StIdle;
      default: state_d = StIdle;
    endcase
    // Counter only runs inside timed phases and restarts on every transition.
    if (state_d != state_q || state_q == StIdle || state_q == StDone) cnt_d = '0;
  end

  always_ff @(posedge input_clock1_clk_1 or posedge input_reset1_rst_2) begin
    if (input_reset1_rst_2) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (state_q == StIdle && input_write_req_3) hold_q <= input_data_d_4;
    end
  end

  assign master_en          = (state_q == StMOpen);
  assign slave_en           = (state_q == StSOpen);
  assign output_master_en_7 = master_en;
  assign output_slave_en_8  = slave_en;
  assign output_busy_6      = (state_q != StIdle);
  assign output_ack_5       = (state_q == StDone);

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    ms_latch_pair u_pair (
      .clk (input_clock1_clk_1),
      .rst (input_reset1_rst_2),
      .d   (hold_q[i]),
      .men (master_en),
      .sen (slave_en),
      .q   (output_led_q_9[i])
    );
  end

endmodule

// File: tb/tb_ms_latch_sequencer.sv
// Scoreboard bench for ms_latch_sequencer: a default instance and a 3/2 timing
// instance share stimulus, selected by sel; expectations come from phase arithmetic.
module tb_ms_latch_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       req;
  logic       sel;
  logic [1:0] d;

  logic       req_a, ack_a, busy_a, men_a, sen_a;
  logic [1:0] q_a;
  logic       req_b, ack_b, busy_b, men_b, sen_b;
  logic [1:0] q_b;
  logic       obs_ack, obs_busy, obs_men, obs_sen;
  logic [1:0] obs_q;

  always #5 clk = ~clk;

  assign req_a = req & ~sel;
  assign req_b = req & sel;

  ms_latch_sequencer #(.WIDTH(2), .OPEN_CYCLES(2), .GAP_CYCLES(1)) dut_a (
    .input_clock1_clk_1 (clk),
    .input_reset1_rst_2 (rst),
    .input_write_req_3  (req_a),
    .input_data_d_4     (d),
    .output_ack_5       (ack_a),
    .output_busy_6      (busy_a),
    .output_master_en_7 (men_a),
    .output_slave_en_8  (sen_a),
    .output_led_q_9     (q_a)
  );

  ms_latch_sequencer #(.WIDTH(2), .OPEN_CYCLES(3), .GAP_CYCLES(2)) dut_b (
    .input_clock1_clk_1 (clk),
    .input_reset1_rst_2 (rst),
    .input_write_req_3  (req_b),
    .input_data_d_4     (d),
    .output_ack_5       (ack_b),
    .output_busy_6      (busy_b),
    .output_master_en_7 (men_b),
    .output_slave_en_8  (sen_b),
    .output_led_q_9     (q_b)
  );

  assign obs_ack  = sel ? ack_b  : ack_a;
  assign obs_busy = sel ? busy_b : busy_a;
  assign obs_men  = sel ? men_b  : men_a;
  assign obs_sen  = sel ? sen_b  : sen_a;
  assign obs_q    = sel ? q_b    : q_a;

  typedef struct {
    logic [1:0] q;
    int         at;
  } exp_t;

  exp_t       sb[$];
  int         n_cmp = 0;
  int         n_bad = 0;
  int         cyc = 0;
  int         open_c = 2;
  int         gap_c = 1;
  logic [1:0] model_q = 2'b00;
  logic       ack_prev = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every ack rising edge must match the oldest outstanding write.
  always @(negedge clk) begin : monitor
    exp_t e;
    check("no_overlap", 32'(obs_men & obs_sen), 32'(0));
    if (obs_ack && !ack_prev) begin
      if (sb.size() == 0) begin
        check("unexpected_ack", 32'(1), 32'(0));
      end else begin
        e = sb.pop_front();
        check("sb_q", 32'(obs_q), 32'(e.q));
        check("sb_ack_cycle", 32'(cyc), 32'(e.at));
      end
    end
    ack_prev = obs_ack;
  end

  // Entered at a negedge with the DUT idle; that negedge is cycle 0.
  // drop_at: cycle in which req falls; rst_at: cycle in which reset hits (0 = never).
  task automatic do_write(input logic [1:0] wd, input int drop_at, input bit toggle,
                          input int rst_at);
    int         lat;
    int         qc;
    int         last;
    logic [1:0] prev;
    exp_t       e;
    lat  = 2 * open_c + 2 * gap_c + 1;
    qc   = open_c + gap_c + 1;
    last = (drop_at > lat) ? drop_at : lat;
    prev = model_q;
    d    = wd;
    req  = 1'b1;
    e.q  = wd;
    e.at = cyc + lat;
    sb.push_back(e);
    for (int n = 1; n <= last + 1; n++) begin
      @(negedge clk);
      check("master_en", 32'(obs_men), 32'(n >= 1 && n <= open_c));
      check("slave_en", 32'(obs_sen), 32'(n >= qc && n <= 2 * open_c + gap_c));
      check("q", 32'(obs_q), 32'((n >= qc) ? wd : prev));
      check("busy", 32'(obs_busy), 32'(n <= last));
      check("ack", 32'(obs_ack), 32'(n >= lat && n <= last));
      if (n == qc) model_q = wd;
      if (n == rst_at) begin
        rst = 1'b1;
        #1;
        check("rst_q", 32'(obs_q), 32'(0));
        check("rst_ack", 32'(obs_ack), 32'(0));
        check("rst_busy", 32'(obs_busy), 32'(0));
        check("rst_en", 32'({obs_men, obs_sen}), 32'(0));
        void'(sb.pop_back());
        model_q = 2'b00;
        req = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        return;
      end
      if (n == drop_at) req = 1'b0;
      if (toggle) d = ~d;
    end
  endtask

  initial begin
    rst = 1'b1;
    req = 1'b0;
    d   = 2'b00;
    sel = 1'b0;
    @(negedge clk);
    check("reset_q", 32'(obs_q), 32'(0));
    check("reset_busy", 32'(obs_busy), 32'(0));
    check("reset_ack", 32'(obs_ack), 32'(0));
    @(negedge clk);
    rst = 1'b0;

    // Load 2'b11, then reset while idle: outputs clear before any clock edge.
    do_write(2'b11, 1, 1'b0, 0);
    check("pre_reset_q", 32'(obs_q), 32'(2'b11));
    rst = 1'b1;
    #1;
    check("async_rst_q", 32'(obs_q), 32'(0));
    check("async_rst_flags", 32'({obs_ack, obs_busy, obs_men, obs_sen}), 32'(0));
    model_q = 2'b00;
    @(negedge clk);
    rst = 1'b0;

    do_write(2'b10, 9, 1'b0, 0);  // req held, dropped in cycle 9
    do_write(2'b01, 3, 1'b1, 0);  // data toggles after acceptance
    do_write(2'b01, 1, 1'b0, 0);  // one-cycle req pulse
    do_write(2'b00, 1, 1'b0, 0);
    do_write(2'b11, 20, 1'b0, 5); // reset mid-transaction
    do_write(2'b10, 8, 1'b0, 0);  // next write completes normally

    for (int i = 0; i < 6; i++) begin
      do_write(2'($urandom_range(0, 3)), $urandom_range(1, 10), 1'($urandom_range(0, 1)), 0);
    end

    // Longer phases: earlier resets cleared dut_b, which has been idle since.
    sel     = 1'b1;
    open_c  = 3;
    gap_c   = 2;
    model_q = 2'b00;
    for (int i = 0; i < 20; i++) begin
      do_write(2'($urandom_range(0, 3)), $urandom_range(1, 14), 1'($urandom_range(0, 1)), 0);
    end

    @(negedge clk);
    check("sb_drained", 32'(sb.size()), 32'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
